// File: rtl/led_step_scheduler.sv
// LED step scheduler: turns the selected divider tap into single-cycle step enables and
// applies speed changes on step boundaries. Define BOUNCE_DIR_EN for ping-pong direction.
module led_step_scheduler #(
  parameter logic [2:0]  SEL_INIT    = 3'd4,
  parameter int unsigned DB_W        = 20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK_TOP,
  input  logic       RST_TOP,
  input  logic [7:0] DIV_TAPS,
  input  logic       KEY_UP,
  input  logic       KEY_DN,
  input  logic       KEY_RUN,
  output logic [2:0] SEL_OUT,
  output logic       STEP_EN,
  output logic       DIR,
  output logic [2:0] STEP_CNT,
  output logic [1:0] STATE
);

  localparam int unsigned NKEYS = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    SWITCH = 2'd3
  } state_t;

  state_t                 state;
  logic [NKEYS-1:0]       key_raw;
  logic [SYNC_STAGES-1:0] sync_q [NKEYS];
  logic [DB_W-1:0]        db_cnt [NKEYS];
  logic [NKEYS-1:0]       db_lvl;
  logic [NKEYS-1:0]       db_lvl_q;
  logic [NKEYS-1:0]       press;
  logic                   up_p, dn_p, run_p;
  logic [2:0]             pending_sel;
  logic [2:0]             pend_nxt;
  logic                   spd_upd;
  logic                   tap_r, tap_q, tick;
  logic                   stepping;

  assign key_raw = {KEY_RUN, KEY_DN, KEY_UP};
  assign press   = db_lvl & ~db_lvl_q;
  assign up_p    = press[0];
  assign dn_p    = press[1];
  assign run_p   = press[2];
  assign tick    = tap_r & ~tap_q;
  assign stepping = tick && (state == RUN || state == SWITCH);
  assign STATE   = state;

  // Synchronize each key, then accept a new level only after it has been stable for 2^DB_W cycles.
  always_ff @(posedge CLK_TOP or posedge RST_TOP) begin
    if (RST_TOP) begin
      for (int k = 0; k < NKEYS; k++) begin
        sync_q[k] <= '0;
        db_cnt[k] <= '0;
      end
      db_lvl   <= '0;
      db_lvl_q <= '0;
    end else begin
      db_lvl_q <= db_lvl;
      for (int k = 0; k < NKEYS; k++) begin
        sync_q[k] <= {sync_q[k][SYNC_STAGES-2:0], key_raw[k]};
        if (sync_q[k][SYNC_STAGES-1] == db_lvl[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == '1) begin
          db_lvl[k] <= sync_q[k][SYNC_STAGES-1];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // Saturating speed request; simultaneous up and down cancel out.
  always_comb begin
    pend_nxt = pending_sel;
    if (up_p && !dn_p && pending_sel != 3'd0) begin
      pend_nxt = pending_sel - 3'd1;
    end else if (dn_p && !up_p && pending_sel != 3'd7) begin
      pend_nxt = pending_sel + 3'd1;
    end
  end

`ifdef BOUNCE_DIR_EN
  logic dir_q;
  assign DIR = dir_q;
`else
  assign DIR = 1'b0;
`endif

  always_ff @(posedge CLK_TOP or posedge RST_TOP) begin
    if (RST_TOP) begin
      state       <= IDLE;
      SEL_OUT     <= SEL_INIT;
      pending_sel <= SEL_INIT;
      spd_upd     <= 1'b0;
      STEP_EN     <= 1'b0;
      STEP_CNT    <= 3'd0;
      tap_r       <= 1'b0;
      tap_q       <= 1'b0;
`ifdef BOUNCE_DIR_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      pending_sel <= pend_nxt;
      spd_upd     <= up_p ^ dn_p;
      tap_r       <= DIV_TAPS[SEL_OUT];
      tap_q       <= tap_r;
      STEP_EN     <= stepping;
      if (stepping) begin
        STEP_CNT <= STEP_CNT + 3'd1;
`ifdef BOUNCE_DIR_EN
        if (STEP_CNT == 3'd7) dir_q <= ~dir_q;
`endif
      end
      case (state)
        IDLE: begin
          if (spd_upd) SEL_OUT <= pending_sel;
          if (run_p) state <= RUN;
        end
        RUN: begin
          if (run_p) state <= PAUSE;
          else if (pending_sel != SEL_OUT) state <= SWITCH;
        end
        PAUSE: begin
          if (spd_upd) SEL_OUT <= pending_sel;
          if (run_p) state <= RUN;
        end
        SWITCH: begin
          // New tap takes over on the step; preload both edge registers so its current level is no edge.
          if (tick) begin
            SEL_OUT <= pending_sel;
            tap_r   <= DIV_TAPS[pending_sel];
            tap_q   <= DIV_TAPS[pending_sel];
            state   <= run_p ? PAUSE : RUN;
          end else if (run_p) begin
            state <= PAUSE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
